// File: rtl/vote_logger_if.sv
// Voting front-end bus: candidate buttons and mode in,
// per-candidate counts and vote status out.
interface vote_logger_if #(
    parameter int CNT_W = 8
);
    logic             mode;
    logic             button1;
    logic             button2;
    logic             button3;
    logic             button4;
    logic [CNT_W-1:0] candi1_votes;
    logic [CNT_W-1:0] candi2_votes;
    logic [CNT_W-1:0] candi3_votes;
    logic [CNT_W-1:0] candi4_votes;
    logic             casted_vote;
    logic             overflow;

    modport master (
        output mode,
        output button1,
        output button2,
        output button3,
        output button4,
        input  candi1_votes,
        input  candi2_votes,
        input  candi3_votes,
        input  candi4_votes,
        input  casted_vote,
        input  overflow
    );

    modport slave (
        input  mode,
        input  button1,
        input  button2,
        input  button3,
        input  button4,
        output candi1_votes,
        output candi2_votes,
        output candi3_votes,
        output candi4_votes,
        output casted_vote,
        output overflow
    );
endinterface

// File: rtl/vote_logger.sv
// Voting-mode front end: button qualification (hold, one-hot,
// release lockout) and saturating per-candidate vote counters.
module vote_logger #(
    parameter int HOLD_CYCLES    = 10,
    parameter int LOCKOUT_CYCLES = 4,
    parameter int CNT_W          = 8
) (
    input logic         clock,
    input logic         reset,
    vote_logger_if.slave bus
);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        RELEASE,
        LOCKOUT
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [3:0]       btn;
    logic             any_btn;
    logic             onehot_btn;
    logic [1:0]       btn_idx;
    logic [1:0]       sel_q;
    logic [3:0]       sel_mask;
    logic [HW-1:0]    hold_cnt_q;
    logic [LW-1:0]    lock_cnt_q;
    logic             hold_abort;
    logic             hold_done;
    logic             lock_done;

    logic             start_hold;
    logic             step_hold;
    logic             accept;
    logic             clr_lock;
    logic             step_lock;

    logic [CNT_W-1:0] votes_q [4];
    logic             casted_q;
    logic             overflow_q;

    assign btn        = {bus.button4, bus.button3,
                         bus.button2, bus.button1};
    assign any_btn    = |btn;
    assign onehot_btn = $onehot(btn);
    assign sel_mask   = 4'b0001 << sel_q;

    // A hold survives only while the latched button alone stays down in voting mode
    assign hold_abort = bus.mode || !btn[sel_q]
                        || (|(btn & ~sel_mask));
    assign hold_done  = (hold_cnt_q + HW'(1)) == HW'(HOLD_CYCLES);
    assign lock_done  = (lock_cnt_q + LW'(1)) == LW'(LOCKOUT_CYCLES);

    // Index of the pressed button; only meaningful when exactly one is high
    always_comb begin
        btn_idx = 2'd0;
        case (1'b1)
            btn[0]:  btn_idx = 2'd0;
            btn[1]:  btn_idx = 2'd1;
            btn[2]:  btn_idx = 2'd2;
            btn[3]:  btn_idx = 2'd3;
            default: btn_idx = 2'd0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!bus.mode && onehot_btn) state_d = HOLD;
            end
            HOLD: begin
                if (hold_abort)     state_d = IDLE;
                else if (hold_done) state_d = RELEASE;
            end
            RELEASE: begin
                if (!any_btn) state_d = LOCKOUT;
            end
            LOCKOUT: begin
                if (!any_btn && lock_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM datapath controls
    always_comb begin
        start_hold = 1'b0;
        step_hold  = 1'b0;
        accept     = 1'b0;
        clr_lock   = 1'b0;
        step_lock  = 1'b0;
        unique case (state_q)
            IDLE: begin
                start_hold = !bus.mode && onehot_btn;
            end
            HOLD: begin
                if (!hold_abort) begin
                    accept    = hold_done;
                    step_hold = !hold_done;
                end
            end
            RELEASE: begin
                clr_lock = !any_btn;
            end
            LOCKOUT: begin
                // a press (or bounce) restarts the idle window
                clr_lock  = any_btn || lock_done;
                step_lock = !any_btn && !lock_done;
            end
            default: ;
        endcase
    end

    // Hold/lockout counters and latched candidate
    always_ff @(posedge clock) begin
        if (reset) begin
            hold_cnt_q <= '0;
            lock_cnt_q <= '0;
            sel_q      <= 2'd0;
        end else begin
            if (start_hold) begin
                hold_cnt_q <= HW'(1);
                sel_q      <= btn_idx;
            end else if (step_hold) begin
                hold_cnt_q <= hold_cnt_q + HW'(1);
            end else if (state_q == HOLD) begin
                hold_cnt_q <= '0;
            end
            if (clr_lock)       lock_cnt_q <= '0;
            else if (step_lock) lock_cnt_q <= lock_cnt_q + LW'(1);
        end
    end

    // Saturating vote counters, vote pulse and sticky overflow
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) votes_q[i] <= '0;
            casted_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            casted_q <= accept;
            if (accept) begin
                if (&votes_q[sel_q]) overflow_q <= 1'b1;
                else votes_q[sel_q] <= votes_q[sel_q] + CNT_W'(1);
            end
        end
    end

    assign bus.candi1_votes = votes_q[0];
    assign bus.candi2_votes = votes_q[1];
    assign bus.candi3_votes = votes_q[2];
    assign bus.candi4_votes = votes_q[3];
    assign bus.casted_vote  = casted_q;
    assign bus.overflow     = overflow_q;
endmodule

// File: tb/tb_vote_logger.sv
// Bench for vote_logger: table segments, corner sequences and
// random stimulus against a behavioural vote model.
module tb_vote_logger;
    localparam int HOLD = 4;
    localparam int LOCK = 2;
    localparam int CW   = 8;
    localparam int MAXV = (1 << CW) - 1;

    logic clock = 1'b0;
    logic reset = 1'b1;

    vote_logger_if #(.CNT_W(CW)) bus ();

    vote_logger #(
        .HOLD_CYCLES   (HOLD),
        .LOCKOUT_CYCLES(LOCK),
        .CNT_W         (CW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    int pulses = 0;

    // behavioural model: votes, pending press, release wait, quiet window
    int m_cnt [4];
    bit m_ovf;
    bit m_pulse;
    int m_who;
    int m_streak;
    bit m_wait;
    bit m_lock;
    int m_quiet;

    typedef struct {
        bit       mode;
        bit [3:0] btn;
        int       n;
        int       c1, c2, c3, c4;
        int       pulses;
    } seg_t;

    seg_t segs [$];

    task automatic check(string name, logic [63:0] got,
                         logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        m_ovf = 0; m_pulse = 0; m_who = 0; m_streak = 0;
        m_wait = 0; m_lock = 0; m_quiet = 0;
    endfunction

    function automatic void model_vote(int w);
        m_pulse = 1;
        if (m_cnt[w] == MAXV) m_ovf = 1;
        else m_cnt[w] = m_cnt[w] + 1;
    endfunction

    function automatic void model_step(bit m, bit [3:0] b);
        m_pulse = 0;
        if (m_lock) begin
            if (b != 0) m_quiet = 0;
            else begin
                m_quiet++;
                if (m_quiet >= LOCK) m_lock = 0;
            end
        end else if (m_wait) begin
            if (b == 0) begin
                m_wait = 0; m_lock = 1; m_quiet = 0;
            end
        end else if (m_streak == 0) begin
            if (!m && $countones(b) == 1) begin
                for (int i = 0; i < 4; i++) if (b[i]) m_who = i;
                m_streak = 1;
            end
        end else begin
            if (m || b != 4'(1 << m_who)) m_streak = 0;
            else begin
                m_streak++;
                if (m_streak == HOLD) begin
                    model_vote(m_who);
                    m_streak = 0;
                    m_wait = 1;
                end
            end
        end
    endfunction

    task automatic drive(bit m, bit [3:0] b);
        bus.mode    = m;
        bus.button1 = b[0];
        bus.button2 = b[1];
        bus.button3 = b[2];
        bus.button4 = b[3];
    endtask

    function automatic logic [33:0] outs();
        return {bus.candi1_votes, bus.candi2_votes,
                bus.candi3_votes, bus.candi4_votes,
                bus.casted_vote, bus.overflow};
    endfunction

    function automatic logic [33:0] model_outs();
        return {CW'(m_cnt[0]), CW'(m_cnt[1]),
                CW'(m_cnt[2]), CW'(m_cnt[3]), m_pulse, m_ovf};
    endfunction

    task automatic cyc();
        bit       m;
        bit [3:0] b;
        m = bus.mode;
        b = {bus.button4, bus.button3, bus.button2, bus.button1};
        @(posedge clock);
        if (reset) model_reset();
        else model_step(m, b);
        #1;
        if (bus.casted_vote) pulses++;
        check("model", 64'(outs()), 64'(model_outs()));
    endtask

    task automatic hold(bit m, bit [3:0] b, int n);
        drive(m, b);
        repeat (n) cyc();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 4'b0);
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        drive(0, 4'b0);
        model_reset();

        // reset state
        do_reset();
        check("reset_state", 64'(outs()), 64'd0);

        // exact latency: vote and pulse appear on the 4th edge
        drive(0, 4'b0010);
        for (int i = 1; i <= 6; i++) begin
            cyc();
            check($sformatf("lat_pulse_%0d", i),
                  64'(bus.casted_vote), 64'(i == 4));
            check($sformatf("lat_c2_%0d", i),
                  64'(bus.candi2_votes), 64'(i >= 4 ? 1 : 0));
        end
        hold(0, 4'b0, 4);

        // table-driven segments
        segs.push_back('{0, 4'b0010, 10, 0, 1, 0, 0, 1});
        segs.push_back('{0, 4'b0000,  4, 0, 1, 0, 0, 0});
        segs.push_back('{0, 4'b0100,  3, 0, 1, 0, 0, 0});
        segs.push_back('{0, 4'b0000,  4, 0, 1, 0, 0, 0});
        segs.push_back('{0, 4'b1001,  8, 0, 1, 0, 0, 0});
        segs.push_back('{0, 4'b0000,  2, 0, 1, 0, 0, 0});
        segs.push_back('{0, 4'b0001,  2, 0, 1, 0, 0, 0});
        segs.push_back('{0, 4'b0011,  4, 0, 1, 0, 0, 0});
        segs.push_back('{0, 4'b0000,  2, 0, 1, 0, 0, 0});
        segs.push_back('{0, 4'b0001,  5, 1, 1, 0, 0, 1});
        segs.push_back('{0, 4'b0000,  1, 1, 1, 0, 0, 0});
        segs.push_back('{0, 4'b0001,  1, 1, 1, 0, 0, 0});
        segs.push_back('{0, 4'b0000,  1, 1, 1, 0, 0, 0});
        segs.push_back('{0, 4'b0001,  4, 1, 1, 0, 0, 0});
        segs.push_back('{0, 4'b0000,  2, 1, 1, 0, 0, 0});
        segs.push_back('{0, 4'b0001,  4, 2, 1, 0, 0, 1});
        segs.push_back('{0, 4'b0000,  4, 2, 1, 0, 0, 0});
        segs.push_back('{1, 4'b1000, 10, 2, 1, 0, 0, 0});
        segs.push_back('{1, 4'b0000,  2, 2, 1, 0, 0, 0});
        segs.push_back('{0, 4'b0000,  1, 2, 1, 0, 0, 0});

        do_reset();
        foreach (segs[k]) begin
            pulses = 0;
            hold(segs[k].mode, segs[k].btn, segs[k].n);
            check($sformatf("seg%0d_counts", k),
                  64'({bus.candi1_votes, bus.candi2_votes,
                       bus.candi3_votes, bus.candi4_votes}),
                  64'({CW'(segs[k].c1), CW'(segs[k].c2),
                       CW'(segs[k].c3), CW'(segs[k].c4)}));
            check($sformatf("seg%0d_pulses", k),
                  64'(pulses), 64'(segs[k].pulses));
        end

        // saturation at max count
        do_reset();
        repeat (MAXV) begin
            hold(0, 4'b0001, HOLD);
            hold(0, 4'b0000, LOCK + 1);
        end
        check("sat_pre_c1", 64'(bus.candi1_votes), 64'(MAXV));
        check("sat_pre_ovf", 64'(bus.overflow), 64'd0);
        pulses = 0;
        hold(0, 4'b0001, HOLD);
        hold(0, 4'b0000, LOCK + 1);
        check("sat_c1", 64'(bus.candi1_votes), 64'(MAXV));
        check("sat_pulse", 64'(pulses), 64'd1);
        check("sat_ovf", 64'(bus.overflow), 64'd1);

        // reset in the middle of a hold
        hold(0, 4'b0100, 2);
        reset = 1'b1;
        pulses = 0;
        cyc();
        check("midhold_rst", 64'(outs()), 64'd0);
        reset = 1'b0;
        hold(0, 4'b0000, 5);
        check("midhold_pulses", 64'(pulses), 64'd0);
        check("midhold_after", 64'(outs()), 64'd0);

        // random stimulus against the model
        do_reset();
        repeat (400) begin
            int       r;
            bit       m;
            bit [3:0] b;
            r = $urandom_range(0, 9);
            m = ($urandom_range(0, 7) == 0);
            if (r <= 5)      b = 4'(1 << $urandom_range(0, 3));
            else if (r <= 7) b = 4'b0;
            else             b = 4'($urandom_range(0, 15));
            hold(m, b, $urandom_range(1, 8));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
